uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped 8N1 UART transmitter on the processor's data bus, alongside the data RAM. Decodes `DataAdr`/`MemWrite`/`WriteData` from the `arm` core, buffers bytes in a small FIFO and serializes them on `tx`. Status reads are registered with one-cycle latency, matching the RAM `q` timing, so the top level muxes `ReadData` from `io_sel`.

## Interface
- `BASE_ADDR`, 32'h0000_FF00: register block base; 16-byte aligned.
- `BAUD_DIV`, 434: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `MemWrite` input 1: core store strobe.
- `DataAdr` input 32: core data address.
- `WriteData` input 32: core store data.
- `io_hit` output 1: combinational; high when `DataAdr[31:4] == BASE_ADDR[31:4]`. Top gates RAM `wren` with `~io_hit`.
- `io_sel` output 1: registered `io_hit`; selects `ReadDataIO` over RAM `q`.
- `ReadDataIO` output 32: registered read data.
- `tx` output 1: serial line; idles high.
- `tx_busy` output 1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- Register map, with offset taken from `DataAdr[3:2]`:
  - 0, TXDATA: a write pushes `WriteData[7:0]`; a read returns 0.
  - 1, STATUS: read-only except bit3.
    - bit0: `full`.
    - bit1: `empty`.
    - bit2: `tx_busy`.
    - bit3: `overflow`, sticky; a write of any value to STATUS clears it.
    - [8:4]: FIFO count.
    - All other bits are 0.
  - 2, 3: reserved; reads return 0, writes are ignored.
  - Byte offset `DataAdr[1:0]` is ignored.
- A push when `full` drops the byte and sets `overflow`. If a pop happens in the same cycle as a push while full, the push is accepted and `overflow` is not set.
- Serializer FSM (IDLE, START, DATA, STOP):
  - IDLE: `tx`=1. When the FIFO is non-empty: pop into the shift register, load the bit timer with `BAUD_DIV-1`, go to START.
  - START: `tx`=0 for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0], LSB first. Every `BAUD_DIV` cycles, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for `BAUD_DIV` cycles. At the end: if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Bit timer: 16-bit down-counter, reloaded at every bit boundary.
- Reset values:
  - `tx`=1, `tx_busy`=0, `io_sel`=0, `ReadDataIO`=0.
  - FIFO empty, `overflow`=0, FSM in IDLE.
- Reset mid-frame aborts the frame. `tx` is high from the next edge, and FIFO contents are discarded.

## Timing
- Write sampled at edge E0: the FIFO count reflects it after E0.
- From IDLE, the FSM pops at E1, and `tx` falls after E1.
- Frame length: exactly 10×`BAUD_DIV` cycles from `tx` falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- Read: `DataAdr` is sampled at edge E0. `io_sel` and `ReadDataIO` are valid after E0 and hold until the next edge.
  - `ReadDataIO` is 0 when not hit.
  - STATUS reflects state before E0.
- Simultaneous push and pop: both take effect; the count is unchanged.
- `tx_busy` is registered and updates on the same edge as the FIFO and FSM state.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - Register offset constants.
  - STATUS bit position constants.
- Sub-module `sync_fifo`, parameterized on width and depth:
  - Ports: push, pop, din, dout, full, empty, count.
  - `dout` is first-word fall-through.
- Top of this block: address decode, STATUS/overflow logic, read register, serializer FSM.

## Test plan
- Write 8'hA5 to TXDATA with `BAUD_DIV`=4 -> `tx` falls 2 edges later; line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; then `tx_busy`=0.
- Write 3 bytes back-to-back -> three contiguous 40-cycle frames with no idle cycle between them; STATUS count reads 2 right after the third write.
- `FIFO_DEPTH`=8, 10 writes with no intervening pop -> `full`=1, `overflow`=1, 2 bytes dropped, 8 frames sent. A STATUS write then clears `overflow`.
- Read STATUS at reset -> `io_sel`=1 one cycle later and `ReadDataIO`=32'h0000_0002. Read a non-hit address -> `io_sel`=0, `ReadDataIO`=0, `io_hit`=0.
- Assert reset during DATA bit 3 -> `tx`=1 after the next edge, `tx_busy`=0, STATUS=32'h2; no further frame is sent.
- Write when full while the STOP→START pop happens in the same cycle -> byte accepted, `overflow` stays 0, count stays 8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   // Word offsets within the 16-byte register block (DataAdr[3:2]).
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_MSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/overflow, registered
// read port and the bit-serializer FSM fed from a small TX FIFO.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
   parameter int          BAUD_DIV   = 434,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic        io_hit,
   output logic        io_sel,
   output logic [31:0] ReadDataIO,
   output logic        tx,
   output logic        tx_busy
);

   localparam int          CW         = $clog2(FIFO_DEPTH + 1);
   localparam logic [15:0] BIT_RELOAD = 16'(BAUD_DIV - 1);

   logic [1:0]    reg_off;
   logic          wr_txdata;
   logic          wr_status;
   logic          push_ok;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   logic          frame_next;
   logic          bit_done;
   logic          overflow;
   logic [31:0]   status_word;
   logic          unused_bits;

   uart_state_t   state;
   logic [15:0]   bit_timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   assign io_hit      = (DataAdr[31:4] == BASE_ADDR[31:4]);
   assign reg_off     = DataAdr[3:2];
   assign wr_txdata   = MemWrite && io_hit && (reg_off == REG_TXDATA);
   assign wr_status   = MemWrite && io_hit && (reg_off == REG_STATUS);
   assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

   assign bit_done = (bit_timer == 16'd0);
   assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
   assign push_ok  = wr_txdata && (!fifo_full || fifo_pop);

   // Look-ahead so tx_busy lands on the same edge as the FIFO and FSM it summarises.
   assign count_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
   assign frame_next = ((state != IDLE) && !((state == STOP) && bit_done)) || fifo_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      status_word                                = '0;
      status_word[STAT_FULL]                     = fifo_full;
      status_word[STAT_EMPTY]                    = fifo_empty;
      status_word[STAT_BUSY]                     = tx_busy;
      status_word[STAT_OVERFLOW]                 = overflow;
      status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 5'(fifo_count);
   end

   // Overflow only counts a truly lost byte: a push while full with no pop alongside.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         tx_busy    <= 1'b0;
         io_sel     <= 1'b0;
         ReadDataIO <= '0;
      end else begin
         if (wr_status) begin
            overflow <= 1'b0;
         end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end
         tx_busy    <= frame_next || (count_next != '0);
         io_sel     <= io_hit;
         ReadDataIO <= (io_hit && (reg_off == REG_STATUS)) ? status_word : '0;
      end
   end

   // tx is registered and always set to the level of the bit being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         bit_timer <= '0;
         bit_idx   <= '0;
         shift     <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (fifo_pop) begin
                  shift     <= fifo_dout;
                  bit_timer <= BIT_RELOAD;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  bit_timer <= BIT_RELOAD;
                  bit_idx   <= '0;
                  tx        <= shift[0];
                  state     <= DATA;
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  bit_timer <= BIT_RELOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  bit_timer <= BIT_RELOAD;
                  if (fifo_pop) begin
                     shift <= fifo_dout;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-timeline model of the line and
// register port, directed scenarios with literal pins, then randomized bus traffic.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE  = 32'h0000_FF00;
   localparam int          B     = 4;
   localparam int          DEPTH = 8;
   localparam logic [31:0] NOHIT = 32'h0000_1000;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        MemWrite  = 1'b0;
   logic [31:0] DataAdr   = NOHIT;
   logic [31:0] WriteData = '0;
   logic        io_hit;
   logic        io_sel;
   logic [31:0] ReadDataIO;
   logic        tx;
   logic        tx_busy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_mmio #(
      .BASE_ADDR  (BASE),
      .BAUD_DIV   (B),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWrite   (MemWrite),
      .DataAdr    (DataAdr),
      .WriteData  (WriteData),
      .io_hit     (io_hit),
      .io_sel     (io_sel),
      .ReadDataIO (ReadDataIO),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
   endtask

   // Model: a queue of accepted bytes plus the start cycle of the frame on the line.
   int unsigned cyc      = 0;
   bit          started  = 1'b0;
   logic [7:0]  mq [$];
   bit          m_active = 1'b0;
   int unsigned m_start  = 0;
   logic [7:0]  m_cur    = '0;
   bit          m_ovf    = 1'b0;
   logic        m_tx     = 1'b1;
   logic        m_busy   = 1'b0;
   logic        m_sel    = 1'b0;
   logic [31:0] m_rd     = '0;

   function automatic logic line_bit(input logic [7:0] b, input int unsigned k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s      = '0;
      s[0]   = (mq.size() == DEPTH);
      s[1]   = (mq.size() == 0);
      s[2]   = m_busy;
      s[3]   = m_ovf;
      s[8:4] = 5'(mq.size());
      return s;
   endfunction

   always @(posedge clk) begin
      bit         hit;
      bit         popped;
      bit         was_full;
      logic [1:0] off;
      cyc++;
      started = 1'b1;
      hit     = (DataAdr[31:4] == BASE[31:4]);
      off     = DataAdr[3:2];
      if (reset) begin
         mq.delete();
         m_active = 1'b0;
         m_ovf    = 1'b0;
         m_tx     = 1'b1;
         m_busy   = 1'b0;
         m_sel    = 1'b0;
         m_rd     = '0;
      end else begin
         m_sel    = hit;
         m_rd     = (hit && off == 2'd1) ? model_status() : 32'd0;
         was_full = (mq.size() == DEPTH);
         popped   = 1'b0;
         if (m_active && (cyc - m_start == 10 * B)) m_active = 1'b0;
         if (!m_active && mq.size() > 0) begin
            m_cur    = mq.pop_front();
            m_start  = cyc;
            m_active = 1'b1;
            popped   = 1'b1;
         end
         if (MemWrite && hit && off == 2'd0) begin
            if (!was_full || popped) mq.push_back(WriteData[7:0]);
            else m_ovf = 1'b1;
         end
         if (MemWrite && hit && off == 2'd1) m_ovf = 1'b0;
         m_busy = m_active || (mq.size() > 0);
         m_tx   = m_active ? line_bit(m_cur, (cyc - m_start) / B) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check_output("tx", 32'(tx), 32'(m_tx));
         check_output("tx_busy", 32'(tx_busy), 32'(m_busy));
         check_output("io_sel", 32'(io_sel), 32'(m_sel));
         check_output("ReadDataIO", ReadDataIO, m_rd);
         check_output("io_hit", 32'(io_hit), 32'(DataAdr[31:4] == BASE[31:4]));
      end
   end

   task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
      MemWrite  = we;
      DataAdr   = adr;
      WriteData = data;
      @(posedge clk);
      #2;
      MemWrite  = 1'b0;
      DataAdr   = NOHIT;
      WriteData = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (m_busy && guard < 1000) begin
         idle(1);
         guard++;
      end
      check_output(name, 32'(guard < 1000), 32'd1);
   endtask

   initial begin
      logic [9:0]  seq;
      int          guard;
      int          r;
      int unsigned off;
      int unsigned bo;

      idle(3);
      reset = 1'b0;
      idle(1);

      // STATUS after reset, then a non-hit read.
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("reset_status", ReadDataIO, 32'h0000_0002);
      check_output("reset_io_sel", 32'(io_sel), 32'd1);
      apply_stimulus(1'b0, 32'h0000_0040, '0);
      check_output("nohit_io_sel", 32'(io_sel), 32'd0);
      check_output("nohit_rd", ReadDataIO, 32'd0);
      check_output("nohit_io_hit", 32'(io_hit), 32'd0);

      // Single 0xA5 frame: start falls one edge after the write edge.
      apply_stimulus(1'b1, BASE, 32'hDEAD_BEA5);
      check_output("a5_idle_high", 32'(tx), 32'd1);
      @(posedge clk);
      #1;
      check_output("a5_start_fall", 32'(tx), 32'd0);
      for (int k = 0; k < 10; k++) begin
         repeat ((k == 0) ? 2 : B) @(posedge clk);
         #1;
         seq[k] = tx;
      end
      check_output("a5_line", 32'(seq), 32'(10'b1101001010));
      repeat (2) @(posedge clk);
      #1;
      check_output("a5_busy_done", 32'(tx_busy), 32'd0);
      idle(2);

      // Three back-to-back writes, STATUS read right after.
      apply_stimulus(1'b1, BASE + 32'd1, 32'h11);
      apply_stimulus(1'b1, BASE + 32'd2, 32'h22);
      apply_stimulus(1'b1, BASE + 32'd3, 32'h33);
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("three_status", ReadDataIO, 32'h0000_0024);
      drain("three_drain");
      idle(3);

      // Overflow: one byte on the line, then ten more writes.
      apply_stimulus(1'b1, BASE, 32'h01);
      idle(2);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b1, BASE, 32'(8'h80 + i));
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("ovf_status", ReadDataIO, 32'h0000_008D);
      apply_stimulus(1'b1, BASE + 32'd4, 32'hFFFF_FFFF);
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("ovf_cleared", ReadDataIO, 32'h0000_0085);

      // Push while full on the very edge the STOP->START pop happens.
      guard = 0;
      while (!(m_active && (cyc + 1 - m_start == 10 * B) && mq.size() == DEPTH) && guard < 200) begin
         idle(1);
         guard++;
      end
      check_output("edge_wait", 32'(guard < 200), 32'd1);
      apply_stimulus(1'b1, BASE, 32'h5A);
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("edge_push_status", ReadDataIO, 32'h0000_0085);
      drain("edge_drain");
      idle(2);

      // Reset during data bit 3 with another byte still queued.
      apply_stimulus(1'b1, BASE, 32'hC3);
      apply_stimulus(1'b1, BASE, 32'h3C);
      guard = 0;
      while (!(m_active && (cyc - m_start == 4 * B + 1)) && guard < 100) begin
         idle(1);
         guard++;
      end
      check_output("bit3_wait", 32'(guard < 100), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("midreset_tx", 32'(tx), 32'd1);
      check_output("midreset_busy", 32'(tx_busy), 32'd0);
      reset = 1'b0;
      apply_stimulus(1'b0, BASE + 32'd4, '0);
      check_output("midreset_status", ReadDataIO, 32'h0000_0002);
      idle(60);

      // Randomized bus traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         r   = $urandom_range(99);
         off = $urandom_range(3);
         bo  = $urandom_range(3);
         if (r < 35) begin
            idle(1);
         end else if (r < 55) begin
            apply_stimulus(1'b1, BASE + bo, $urandom);
         end else if (r < 70) begin
            apply_stimulus(1'b0, BASE + 32'd4 + bo, $urandom);
         end else if (r < 75) begin
            apply_stimulus(1'b1, BASE + 32'd4 + bo, $urandom);
         end else if (r < 85) begin
            apply_stimulus(1'(r & 1), BASE + off * 4 + bo, $urandom);
         end else if (r < 92) begin
            apply_stimulus(1'(r & 1), BASE + 32'd16 + off * 4, $urandom);
         end else if (r < 99) begin
            apply_stimulus(1'(r & 1), $urandom, $urandom);
         end else begin
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end
      end
      drain("final_drain");
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
